serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 96 +++++++++
 tb/tb_serial_adder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice and a carry flop compute {cout, sum} = a + b + cin
// LSB first over N cycles, with a start/busy/done handshake.
module serial_adder #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state, state_nx;
  logic [N-1:0]   a_sr, b_sr, r_sr;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic           accept_c, last_c, bit_c, carry_c;

  // Next-state, full-adder slice and handshake decode
  always_comb begin
    state_nx = state;
    accept_c = 1'b0;
    last_c   = 1'b0;
    bit_c    = a_sr[0] ^ b_sr[0] ^ carry;
    carry_c  = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept_c = 1'b1;
          state_nx = SHIFT;
        end else begin
          state_nx = IDLE;
        end
      end
      SHIFT: begin
        if (cnt == LAST) begin
          last_c   = 1'b1;
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Operand/result shifters, carry, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      busy <= (state_nx == SHIFT);
      done <= (state_nx == DONE);
      if (accept_c) begin
        a_sr  <= a;
        b_sr  <= b;
        carry <= cin;
        cnt   <= '0;
      end else if (state == SHIFT) begin
        a_sr  <= a_sr >> 1;
        b_sr  <= b_sr >> 1;
        r_sr  <= {bit_c, r_sr[N-1:1]};
        carry <= carry_c;
        cnt   <= cnt + CW'(1);
      end
      // Result is published only once the final bit is known
      if (last_c) begin
        sum  <= {bit_c, r_sr[N-1:1]};
        cout <= carry_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (N=8): vector table, corner sequences and a random sweep,
// with a scoreboard of expected results checked on each done pulse.
module tb_serial_adder;

  localparam int unsigned N = 8;

  logic         clk, rst_n, start, cin;
  logic [N-1:0] a, b;
  logic         busy, done, cout;
  logic [N-1:0] sum;

  serial_adder #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  typedef struct {
    logic [7:0]  sum;
    logic        cout;
    int unsigned dc;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc;
  int          checks, fails;
  logic        prev_done;
  logic [7:0]  prev_sum;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Expected done lands N edges after the accepting edge, which is the next posedge
  task automatic push(input logic [7:0] s, input logic c);
    exp_t e;
    e.sum  = s;
    e.cout = c;
    e.dc   = cyc + 1 + N;
    exp_q.push_back(e);
  endtask

  task automatic mon();
    exp_t e;
    if (rst_n) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("sum", 32'(sum), 32'(e.sum));
          chk("cout", 32'(cout), 32'(e.cout));
          chk("done_latency", cyc, e.dc);
        end
        if (prev_done) chk("done_pulse_width", 32'(prev_done), 32'(0));
      end
      if (busy) chk("sum_stable_in_shift", 32'(sum), 32'(prev_sum));
    end
    prev_done = done;
    prev_sum  = sum;
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
  endtask

  // Called at a negedge in IDLE or DONE; returns at the negedge of the DONE cycle
  task automatic op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tci,
                    input logic [7:0] es, input logic ec, input bit toggle);
    a = ta; b = tb_v; cin = tci; start = 1'b1;
    push(es, ec);
    tick();
    if (!toggle) start = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      chk("busy_in_shift", 32'(busy), 32'(1));
      if (toggle) begin
        a = 8'($urandom);
        b = 8'($urandom);
        cin = 1'($urandom);
      end
      tick();
    end
    chk("busy_low_in_done", 32'(busy), 32'(0));
    start = 1'b0;
  endtask

  vec_t       vecs[7];
  logic [8:0] ref9;
  logic [7:0] ra, rb;
  logic       rc;

  initial begin
    vecs[0] = '{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

    checks = 0; fails = 0; cyc = 0;
    prev_done = 1'b0; prev_sum = 8'h00;
    start = 1'b0; a = '0; b = '0; cin = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    chk("reset_sum", 32'(sum), 32'(0));
    chk("reset_cout", 32'(cout), 32'(0));
    tick(); tick();
    rst_n = 1'b1;

    // Table vectors; first one is accepted on the first edge after reset release
    for (int i = 0; i < 7; i++) begin
      op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, 1'b0);
      tick();
      chk("idle_after_done", 32'(done), 32'(0));
    end

    // Start held high and operands toggled through SHIFT
    op(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, 1'b1);
    tick();
    chk("single_op_held_start", 32'(busy), 32'(0));

    // Back-to-back: new start during the DONE cycle
    op(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, 1'b0);
    op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
    tick();

    // Reset asserted after 4 shifts aborts the operation
    a = 8'hF0; b = 8'h0F; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("busy_before_abort", 32'(busy), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_sum", 32'(sum), 32'(0));
    chk("abort_cout", 32'(cout), 32'(0));
    tick(); tick();
    rst_n = 1'b1;
    repeat (N + 4) tick();
    op(8'h55, 8'h2A, 1'b1, 8'h80, 1'b0, 1'b0);
    tick();

    // Random sweep against a 9-bit reference
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      ref9 = 9'(ra) + 9'(rb) + 9'(rc);
      op(ra, rb, rc, ref9[7:0], ref9[8], 1'b0);
      if ($urandom_range(1, 0) == 1) tick();
    end

    repeat (3) tick();
    chk("all_results_seen", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
